// File: rtl/word_triplet_packer.sv
// Packs three consecutive input words into one frame (a, bb, bbbb) with valid/ready on both sides.
// Latency: o_valid rises the cycle after the third accepted word; stalls hold the frame and block input.
module word_triplet_packer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_abort,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_bb,
  output logic [WIDTH-1:0] o_bbbb,
  output logic [15:0]      o_frame_count,
  output logic             o_timeout_err
);

  typedef enum logic [1:0] {EMPTY, HAVE_A, HAVE_BB, FULL} state_t;

  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, bb_q, bbbb_q;
  logic [WIDTH-1:0] a_nxt, bb_nxt, bbbb_nxt;
  logic [15:0]      idle_q, idle_nxt;
  logic [15:0]      cnt_q, cnt_nxt;
  logic             err_q, err_nxt;
  logic             partial, aborting, accept, deliver, expired;

  assign partial  = (state == HAVE_A) || (state == HAVE_BB);
  assign aborting = partial && i_abort;

  // Handshakes are gated by reset so nothing looks live while i_rst_n is low.
  assign o_ready = i_rst_n && ((state == FULL) ? i_ready : !aborting);
  assign o_valid = i_rst_n && (state == FULL);

  assign accept  = i_valid && o_ready;
  assign deliver = o_valid && i_ready;
  assign expired = partial && !accept && !aborting && (idle_q == IDLE_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= EMPTY;
      a_q    <= '0;
      bb_q   <= '0;
      bbbb_q <= '0;
      idle_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_q    <= a_nxt;
      bb_q   <= bb_nxt;
      bbbb_q <= bbbb_nxt;
      idle_q <= idle_nxt;
      cnt_q  <= cnt_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    bb_nxt    = bb_q;
    bbbb_nxt  = bbbb_q;
    idle_nxt  = idle_q;
    err_nxt   = 1'b0;
    cnt_nxt   = cnt_q + 16'(deliver);

    case (state)
      EMPTY: begin
        idle_nxt = '0;
        if (accept) begin
          a_nxt     = i_data;
          state_nxt = HAVE_A;
        end
      end
      HAVE_A, HAVE_BB: begin
        if (aborting) begin
          state_nxt = EMPTY;
          idle_nxt  = '0;
        end else if (accept) begin
          idle_nxt = '0;
          if (state == HAVE_A) begin
            bb_nxt    = i_data;
            state_nxt = HAVE_BB;
          end else begin
            bbbb_nxt  = i_data;
            state_nxt = FULL;
          end
        end else if (expired) begin
          state_nxt = EMPTY;
          idle_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          idle_nxt = idle_q + 16'd1;
        end
      end
      FULL: begin
        idle_nxt = '0;
        // Accepting here implies i_ready, so the held frame leaves on this same edge.
        if (accept) begin
          a_nxt     = i_data;
          state_nxt = HAVE_A;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign o_a           = a_q;
  assign o_bb          = bb_q;
  assign o_bbbb        = bbbb_q;
  assign o_frame_count = cnt_q;
  assign o_timeout_err = err_q;

endmodule

// File: doc/word_triplet_packer.md
WORD_TRIPLET_PACKER -- requirements
Module: word_triplet_packer

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, bit width of each data word and of each output field.
REQ-002 SHALL provide parameter TIMEOUT, default 100, idle cycles allowed between words of one frame before the partial frame is discarded; legal range 1..65535.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL provide ports (name, direction, width, meaning):
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  block can accept a word.
- i_data  input  WIDTH  upstream word.
- i_abort  input  1  discard the partial frame.
- o_valid  output  1  complete frame presented.
- i_ready  input  1  downstream accepts the frame.
- o_a  output  WIDTH  first word of the frame.
- o_bb  output  WIDTH  second word of the frame.
- o_bbbb  output  WIDTH  third word of the frame.
- o_frame_count  output  16  number of frames delivered.
- o_timeout_err  output  1  one-cycle pulse when a partial frame is dropped by timeout.

Function
REQ-005 SHALL implement states EMPTY, HAVE_A, HAVE_BB and FULL.
REQ-006 SHALL accept an input word on any rising edge where i_valid=1 and o_ready=1.
REQ-007 SHALL drive o_ready=1 in EMPTY, HAVE_A and HAVE_BB, and o_ready=i_ready in FULL.
REQ-008 SHALL, on an accepted word, make the following captures and transitions:
- EMPTY: capture into o_a, go to HAVE_A.
- HAVE_A: capture into o_bb, go to HAVE_BB.
- HAVE_BB: capture into o_bbbb, go to FULL.
REQ-009 SHALL assert o_valid only in FULL, combinationally from state, so first-word-to-o_valid latency is 3 accepted words, with o_valid high in the cycle after the third acceptance.
REQ-010 SHALL hold o_a, o_bb and o_bbbb stable while o_valid=1 and i_ready=0.
REQ-011 SHALL complete a frame on a rising edge with o_valid=1 and i_ready=1, and SHALL then increment o_frame_count by 1, wrapping 65535 -> 0.
REQ-012 SHALL, on frame completion without a simultaneous input acceptance, go to EMPTY.
REQ-013 SHALL, when frame completion and input acceptance occur on the same edge in FULL, capture i_data into o_a and go to HAVE_A.
REQ-014 SHALL keep a 16-bit idle counter that clears on every accepted word and on entry to EMPTY, and increments each cycle in HAVE_A or HAVE_BB with no acceptance.
REQ-015 SHALL, when the idle counter reaches TIMEOUT-1 in a cycle with no acceptance:
- go to EMPTY on the next edge;
- pulse o_timeout_err high for exactly one cycle, in that next cycle.
REQ-016 SHALL, when i_abort=1 in HAVE_A or HAVE_BB:
- go to EMPTY on the next edge;
- ignore any simultaneous i_valid, and drive o_ready=0 in that cycle;
- not pulse o_timeout_err, and give abort priority over timeout.
REQ-017 SHALL ignore i_abort in EMPTY and FULL.
REQ-018 SHALL not change o_frame_count on abort or timeout.
REQ-019 SHALL leave output fields unchanged on abort or timeout, with their contents don't-care while o_valid=0.

Reset
REQ-020 SHALL, while i_rst_n=0 and independent of i_clk, force:
- state to EMPTY;
- o_a, o_bb, o_bbbb to 0;
- o_frame_count, the idle counter and o_timeout_err to 0.
REQ-021 SHALL, while i_rst_n=0, drive o_valid=0 and o_ready=0.
REQ-022 SHALL drive o_ready=1 from the first cycle after i_rst_n deasserts.
REQ-023 SHALL, on reset asserted mid-frame or in FULL, drop the held frame with no o_frame_count increment.

Verification
REQ-024 SHALL cover basic framing:
- stimulus: words 0x1, 0xA, 0x64 on consecutive cycles, i_ready=1;
- response: o_valid=1 for one cycle with o_a=1, o_bb=10, o_bbbb=100, and o_frame_count 0 -> 1.
REQ-025 SHALL cover backpressure:
- stimulus: frame complete, i_ready=0 for 5 cycles while i_valid=1;
- response: o_ready=0, outputs stable, no word lost;
- stimulus then: i_ready=1 with i_valid=1;
- response: frame delivered, new word captured into o_a, state HAVE_A.
REQ-026 SHALL cover timeout:
- stimulus: TIMEOUT=10, one word, then i_valid=0 for 10 cycles;
- response: o_timeout_err pulses once, state EMPTY;
- stimulus then: next three words;
- response: they form a fresh frame.
REQ-027 SHALL cover abort:
- stimulus: two words, then i_abort=1 with i_valid=1;
- response: that word is not accepted, no error pulse, state EMPTY, o_frame_count unchanged.
REQ-028 SHALL cover counter wrap:
- stimulus: 65536 frames delivered;
- response: o_frame_count returns to 0.
REQ-029 SHALL cover asynchronous reset:
- stimulus: i_rst_n pulsed low between clock edges while in FULL;
- response: o_valid and o_ready drop immediately, all outputs 0.
